// File: rtl/flock_draw_sequencer.sv
// flock_draw_sequencer: per frame tick, erases then redraws each of NUM_SPRITES birds one pixel per clock,
// then advances every bird; the pixel stream drives a VGA adapter plot port.
module flock_draw_sequencer #(
  parameter int NUM_SPRITES = 4,
  parameter int STEP = 1,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int X_INIT = 5,
  parameter int SPACING = 40,
  parameter int Y_INIT = 7,
  parameter logic [2:0] DRAW_COLOUR = 3'b111,
  parameter logic [2:0] ERASE_COLOUR = 3'b000
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     start,
  input  logic [NUM_SPRITES-1:0]   enable,
  input  logic [7*NUM_SPRITES-1:0] y_in,
  output logic [7:0]               x_out,
  output logic [6:0]               y_out,
  output logic [2:0]               colour,
  output logic                     plot,
  output logic [2:0]               sprite_idx,
  output logic                     busy,
  output logic                     done
);
  typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;
  localparam logic [2:0] LAST = 3'(NUM_SPRITES - 1);
  state_t state;
  logic [2:0] spr;
  logic [3:0] pix;
  logic [7:0] mask, vis_prev, pose, prev_pose;
  logic [7:0] x_pos [8];
  logic [7:0] prev_x [8];
  logic [6:0] y_pos [8];
  logic [6:0] prev_y [8];
  logic [55:0] y_pad;
  logic [7:0] ax;
  logic [6:0] ay;
  logic ap, erase, draw, inb;
  logic signed [8:0] p9, dx, dy, px, py;
  assign y_pad = 56'(y_in);
  always_ff @(posedge CLOCK_50)
    if (reset) begin
      state <= IDLE;
      spr <= '0;
      pix <= '0;
      mask <= '0;
    end else
      case (state)
        IDLE: if (start) begin
          state <= ERASE;
          spr <= '0;
          pix <= '0;
          mask <= 8'(enable);
        end
        ERASE: begin
          pix <= pix == 4'd9 ? 4'd0 : pix + 4'd1;
          state <= pix == 4'd9 ? DRAW : ERASE;
        end
        DRAW: begin
          pix <= pix == 4'd9 ? 4'd0 : pix + 4'd1;
          state <= pix != 4'd9 ? DRAW : spr == LAST ? DONE : ERASE;
          spr <= pix != 4'd9 ? spr : spr == LAST ? 3'd0 : spr + 3'd1;
        end
        default: state <= IDLE;
      endcase
  // Slots beyond NUM_SPRITES are never selected, so updating them unconditionally is harmless.
  always_ff @(posedge CLOCK_50)
    for (int i = 0; i < 8; i++)
      if (reset) begin
        x_pos[i] <= 8'((X_INIT + i * SPACING) % SCREEN_W);
        prev_x[i] <= 8'((X_INIT + i * SPACING) % SCREEN_W);
        y_pos[i] <= 7'(Y_INIT);
        prev_y[i] <= 7'(Y_INIT);
        pose[i] <= 1'b0;
        prev_pose[i] <= 1'b0;
        vis_prev[i] <= 1'b0;
      end else if (state == DONE) begin
        prev_x[i] <= x_pos[i];
        prev_y[i] <= y_pos[i];
        prev_pose[i] <= pose[i];
        vis_prev[i] <= mask[i];
        x_pos[i] <= 8'(int'(x_pos[i]) + STEP >= SCREEN_W ? int'(x_pos[i]) + STEP - SCREEN_W : int'(x_pos[i]) + STEP);
        y_pos[i] <= int'(y_pad[7*i +: 7]) < SCREEN_H ? y_pad[7*i +: 7] : y_pos[i];
        pose[i] <= ~pose[i];
      end
  always_comb begin
    erase = state == ERASE;
    draw = state == DRAW;
    ax = erase ? prev_x[spr] : x_pos[spr];
    ay = erase ? prev_y[spr] : y_pos[spr];
    ap = erase ? prev_pose[spr] : pose[spr];
    p9 = 9'(pix);
    dx = p9 <= 9'sd1 ? 9'sd0 : p9 <= 9'sd6 ? 9'sd1 - p9 : 9'sd4 - p9;
    dy = p9 == 9'sd1 ? 9'sd1 : p9 >= 9'sd7 ? (ap ? 9'sd6 - p9 : p9 - 9'sd6) : 9'sd0;
    px = $signed({1'b0, ax}) + dx;
    py = $signed({2'b0, ay}) + dy;
    inb = !px[8] && int'(px) < SCREEN_W && !py[8] && int'(py) < SCREEN_H;
    x_out = erase || draw ? px[7:0] : 8'd0;
    y_out = erase || draw ? py[6:0] : 7'd0;
    colour = erase ? ERASE_COLOUR : draw ? DRAW_COLOUR : 3'd0;
    plot = inb && (erase && vis_prev[spr] || draw && mask[spr]);
    sprite_idx = spr;
    busy = state != IDLE;
    done = state == DONE;
  end
endmodule

// File: tb/tb_flock_draw_sequencer.sv
// tb_flock_draw_sequencer: random frames checked every cycle against a frame-timeline model,
// plus literal pixel/timing expectations for reset, pose, mask, busy-start and mid-frame reset.
module tb_flock_draw_sequencer;
  localparam int N = 4;
  localparam int FL = 20 * N + 1;
  logic CLOCK_50 = 0, reset = 0, start = 0;
  logic [N-1:0] enable = '1;
  logic [7*N-1:0] y_in;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour, sprite_idx;
  logic plot, busy, done;
  int checks = 0, passes = 0, run = 0, dcount = 0, d0;
  int mx[N], my[N], mp[N], pmx[N], pmy[N], pmp[N], vis[N], msk[N];
  int t = 0;
  int dxt[10] = '{0, 0, -1, -2, -3, -4, -5, -3, -4, -5};
  int dyt[10] = '{0, 1, 0, 0, 0, 0, 0, 1, 2, 3};

  flock_draw_sequencer #(.NUM_SPRITES(N)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .enable(enable), .y_in(y_in),
    .x_out(x_out), .y_out(y_out), .colour(colour), .plot(plot),
    .sprite_idx(sprite_idx), .busy(busy), .done(done)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  task automatic step(int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  // Model: t is the cycle index within the current frame (0 = idle, FL = done cycle).
  always @(negedge CLOCK_50) begin : cmp
    int s, r, p, ax, ay, ap, px, py, ex, ey, ec, epl, es;
    ex = 0; ey = 0; ec = 0; epl = 0; es = 0;
    if (t >= 1 && t < FL) begin
      s = (t - 1) / 20;
      r = (t - 1) % 20;
      p = r % 10;
      ax = r < 10 ? pmx[s] : mx[s];
      ay = r < 10 ? pmy[s] : my[s];
      ap = r < 10 ? pmp[s] : mp[s];
      px = ax + dxt[p];
      py = ay + ((p >= 7 && ap != 0) ? -dyt[p] : dyt[p]);
      ex = px & 255;
      ey = py & 127;
      ec = r < 10 ? 0 : 7;
      es = s;
      epl = (px >= 0 && px < 160 && py >= 0 && py < 120 && (r < 10 ? vis[s] : msk[s]) != 0) ? 1 : 0;
    end
    if (run != 0) begin
      chk("x_out", x_out, ex);
      chk("y_out", y_out, ey);
      chk("colour", colour, ec);
      chk("plot", plot, epl);
      if (t >= 1 && t < FL) chk("sprite_idx", sprite_idx, es);
      chk("busy", busy, t != 0 ? 1 : 0);
      chk("done", done, t == FL ? 1 : 0);
    end
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        mx[i] = (5 + 40 * i) % 160; pmx[i] = mx[i];
        my[i] = 7; pmy[i] = 7; mp[i] = 0; pmp[i] = 0; vis[i] = 0; msk[i] = 0;
      end
      t = 0;
    end else if (t == 0) begin
      if (start) begin
        for (int i = 0; i < N; i++) msk[i] = enable[i];
        t = 1;
      end
    end else if (t == FL) begin
      for (int i = 0; i < N; i++) begin
        pmx[i] = mx[i]; pmy[i] = my[i]; pmp[i] = mp[i]; vis[i] = msk[i];
        mx[i] = (mx[i] + 1) % 160;
        if (y_in[7*i +: 7] < 120) my[i] = y_in[7*i +: 7];
        mp[i] = 1 - mp[i];
      end
      t = 0;
    end else t++;
  end

  always @(negedge CLOCK_50) if (run != 0 && done) dcount++;

  initial begin
    int len;
    y_in = {N{7'd7}};
    reset = 1;
    step(1);
    run = 1;
    step(1);
    chk("reset_x", x_out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_plot", plot, 0);
    reset = 0;
    step(1);
    start = 1; step(1); start = 0;
    chk("f1_erase_plot", plot, 0);
    step(10);
    chk("f1_c11_x", x_out, 5); chk("f1_c11_y", y_out, 7);
    chk("f1_c11_colour", colour, 7); chk("f1_c11_plot", plot, 1);
    step(7);
    chk("f1_c18_x", x_out, 2); chk("f1_c18_y", y_out, 8);
    step(63);
    chk("f1_done", done, 1);
    step(2);
    start = 1; step(1); start = 0;
    chk("f2_erase_plot", plot, 1); chk("f2_erase_colour", colour, 0); chk("f2_erase_x", x_out, 5);
    step(10);
    chk("f2_c11_x", x_out, 6); chk("f2_c11_y", y_out, 7);
    step(7);
    chk("f2_wing_x", x_out, 3); chk("f2_wing_y", y_out, 6);
    step(70);
    d0 = dcount;
    start = 1; step(1); start = 0;
    step(4); start = 1; step(1); start = 0;
    step(34); start = 1; step(1); start = 0;
    step(60);
    chk("busy_start_dones", dcount - d0, 1);
    enable = N'(5);
    start = 1; step(1); start = 0;
    step(30);
    chk("mask_s1_plot", plot, 0);
    step(50);
    chk("mask_done", done, 1);
    step(2);
    enable = N'(4);
    start = 1; step(1); start = 0;
    chk("mask_erase_plot", plot, 1);
    step(10);
    chk("mask_draw_plot", plot, 0);
    step(70);
    chk("mask2_done", done, 1);
    step(2);
    enable = '1;
    start = 1; step(1); start = 0;
    step(14);
    reset = 1; step(1); reset = 0;
    chk("rst_mid_plot", plot, 0); chk("rst_mid_busy", busy, 0); chk("rst_mid_done", done, 0);
    step(1);
    y_in = {N{7'd120}};
    start = 1; step(1); start = 0;
    step(10);
    chk("rst_redraw_x", x_out, 5); chk("rst_redraw_y", y_out, 7); chk("rst_redraw_plot", plot, 1);
    step(75);
    start = 1; step(1); start = 0;
    step(10);
    chk("yclip_x", x_out, 6); chk("yclip_y", y_out, 7);
    step(75);
    for (int f = 0; f < 170; f++) begin
      enable = N'($urandom);
      for (int i = 0; i < N; i++) y_in[7*i +: 7] = 7'($urandom_range(0, 127));
      start = 1; step(1); start = 0;
      len = FL + $urandom_range(0, 3);
      for (int c = 1; c <= len; c++) begin
        start = $urandom_range(0, 15) == 0;
        if ($urandom_range(0, 7) == 0) begin
          enable = N'($urandom);
          y_in[7*$urandom_range(0, N-1) +: 7] = 7'($urandom_range(0, 127));
        end
        step(1);
      end
      start = 0;
      step(1);
    end
    step(FL + 2);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
